// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and FSM state type for the read burst master.
// Imported by the burst calculator and the top-level master.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    // Bursts may never cross this many bytes
    localparam int unsigned BOUNDARY_4K = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_e;

endpackage

// File: rtl/axi_burst_calc.sv
// Combinational burst sizing: beats = min(remaining, MAX_BURST, words left before the 4 KB boundary).
// Only the low 12 address bits matter for the boundary distance.
module axi_burst_calc
    import axi_pkg::*;
#(
    parameter int LEN_WIDTH  = 16,
    parameter int STRB_WIDTH = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic [11:0]          addr_low,
    input  logic [LEN_WIDTH-1:0] remaining,
    output logic [8:0]           beats
);

    localparam int unsigned SIZE = $clog2(STRB_WIDTH);
    localparam int unsigned CW   = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

    logic [12:0]   bytes_to_4k;
    logic [CW-1:0] words_to_4k;
    logic [CW-1:0] rem_ext;
    logic [CW-1:0] max_ext;
    logic [CW-1:0] lim;

    always_comb begin
        bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, addr_low};
        words_to_4k = CW'(bytes_to_4k >> SIZE);
        rem_ext     = CW'(remaining);
        max_ext     = CW'(MAX_BURST);
        lim         = (rem_ext < max_ext) ? rem_ext : max_ext;
        if (words_to_4k < lim) begin
            lim = words_to_4k;
        end
        beats = 9'(lim);
    end

endmodule

// File: rtl/axi_read_burst_master.sv
// AXI4 read-only master: splits a (start address, word count) command into INCR bursts
// and forwards R beats as a valid/ready stream with zero added latency.
module axi_read_burst_master
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int ARID       = 0,
    parameter int MAX_BURST  = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,

    output logic [ID_WIDTH-1:0]   axi_arid,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic [2:0]            axi_arsize,
    output logic [1:0]            axi_arburst,
    output logic                  axi_arlock,
    output logic [3:0]            axi_arcache,
    output logic [2:0]            axi_arprot,
    output logic [3:0]            axi_arqos,
    output logic [3:0]            axi_arregion,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,

    input  logic [ID_WIDTH-1:0]   axi_rid,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,

    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,

    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned SIZE = $clog2(STRB_WIDTH);

    state_e                state;
    state_e                state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [8:0]            beats_q;
    logic [8:0]            beat_cnt;
    logic                  err_q;

    logic [ADDR_WIDTH-1:0] cmd_addr_aligned;
    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [LEN_WIDTH-1:0]  calc_rem;
    logic [8:0]            beats_calc;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  ignored_unused;

    assign ignored_unused   = ^{axi_rid, cmd_addr[SIZE-1:0]};
    assign cmd_addr_aligned = {cmd_addr[ADDR_WIDTH-1:SIZE], {SIZE{1'b0}}};

    // Size the burst from the values being loaded this cycle so beats_q is ready on ADDR entry
    always_comb begin
        calc_addr = addr_q;
        calc_rem  = remaining_q;
        if (state == ST_IDLE) begin
            calc_addr = cmd_addr_aligned;
            calc_rem  = cmd_len;
        end
    end

    axi_burst_calc #(
        .LEN_WIDTH (LEN_WIDTH),
        .STRB_WIDTH(STRB_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .addr_low (calc_addr[11:0]),
        .remaining(calc_rem),
        .beats    (beats_calc)
    );

    assign ar_hs = (state == ST_ADDR) && axi_arready;
    assign r_hs  = (state == ST_DATA) && axi_rvalid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = (cmd_len == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (axi_arready) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_hs && (beat_cnt == 9'd1)) begin
                    state_next = (remaining_q != '0) ? ST_ADDR : ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_ADDR: axi_arvalid = 1'b1;
            ST_DATA: begin
                axi_rready = out_ready;
                out_valid  = axi_rvalid;
                out_last   = axi_rvalid && (beat_cnt == 9'd1) && (remaining_q == '0);
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            beat_cnt    <= '0;
            err_q       <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && cmd_valid) begin
                addr_q      <= cmd_addr_aligned;
                remaining_q <= cmd_len;
                err_q       <= 1'b0;
            end
            if ((state_next == ST_ADDR) && (state != ST_ADDR)) begin
                beats_q <= beats_calc;
            end
            if (ar_hs) begin
                addr_q      <= addr_q + (ADDR_WIDTH'(beats_q) << SIZE);
                remaining_q <= remaining_q - LEN_WIDTH'(beats_q);
                beat_cnt    <= beats_q;
            end
            if (r_hs) begin
                beat_cnt <= beat_cnt - 9'd1;
                if ((axi_rresp != RESP_OKAY) || (axi_rlast != (beat_cnt == 9'd1))) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign axi_arid     = ID_WIDTH'(ARID);
    assign axi_araddr   = addr_q;
    assign axi_arlen    = 8'(beats_q - 9'd1);
    assign axi_arsize   = 3'(SIZE);
    assign axi_arburst  = BURST_INCR;
    assign axi_arlock   = 1'b0;
    assign axi_arcache  = 4'b0011;
    assign axi_arprot   = 3'b000;
    assign axi_arqos    = 4'b0000;
    assign axi_arregion = 4'b0000;
    assign out_data     = axi_rdata;
    assign err          = err_q;

endmodule

// File: tb/tb_axi_read_burst_master.sv
// Self-checking bench: table-driven and random commands against a memory-backed AXI slave,
// with a reference model that derives bursts and the word stream from the address rules.
`timescale 1ns/1ps
module tb_axi_read_burst_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [7:0]  axi_arid;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arlock;
    logic [3:0]  axi_arcache;
    logic [2:0]  axi_arprot;
    logic [3:0]  axi_arqos;
    logic [3:0]  axi_arregion;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [7:0]  axi_rid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    axi_read_burst_master #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .STRB_WIDTH(4),
        .ID_WIDTH  (8),
        .ARID      (0),
        .MAX_BURST (16),
        .LEN_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .axi_arid    (axi_arid),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arsize  (axi_arsize),
        .axi_arburst (axi_arburst),
        .axi_arlock  (axi_arlock),
        .axi_arcache (axi_arcache),
        .axi_arprot  (axi_arprot),
        .axi_arqos   (axi_arqos),
        .axi_arregion(axi_arregion),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rid     (axi_rid),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [28:0] fixed;
    } arlog_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } out_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned len;
        int unsigned dly;
        int unsigned rmode;
        int          err_beat;
        bit          gap;
        int unsigned exp_bursts;
        logic [7:0]  exp_arlen0;
        bit          exp_err;
    } vec_t;

    localparam logic [28:0] AR_FIXED_EXP = {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 4'd0};

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Slave / sink configuration and observation state
    int unsigned cfg_dly = 0;
    int unsigned cfg_rmode = 0;
    int          cfg_err_beat = -1;
    bit          cfg_gap = 1'b0;
    int unsigned tick = 0;
    arlog_t      ar_q[$];
    out_t        out_q[$];
    int unsigned done_cnt = 0;
    int unsigned done_tick = 0;
    int unsigned last_tick = 0;
    logic        err_at_done = 1'b0;
    int unsigned proto_err = 0;
    int          cmd_beat = 0;
    arlog_t      exp_ar[$];

    logic [68:0] ar_bus;
    assign ar_bus = {axi_araddr, axi_arlen, axi_arid, axi_arsize, axi_arburst, axi_arlock,
                     axi_arcache, axi_arprot, axi_arqos, axi_arregion};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: walk the aligned address range in chunks limited by length, 16 beats and 4 KB pages
    task automatic model_bursts(input logic [31:0] a0, input int unsigned n);
        logic [31:0] a;
        int unsigned rem, room, b;
        exp_ar.delete();
        a = a0 & ~32'h3;
        rem = n;
        while (rem > 0) begin
            room = (4096 - int'(a % 4096)) / 4;
            b = rem;
            if (b > 16) b = 16;
            if (b > room) b = room;
            exp_ar.push_back('{a, 8'(b - 1), AR_FIXED_EXP});
            a = a + 32'(4 * b);
            rem = rem - b;
        end
    endtask

    // AXI slave, stream sink and bus monitor: drive on negedge, sample 1 ns later
    initial begin
        int unsigned ar_wait;
        int unsigned rd_left;
        logic [31:0] rd_addr;
        logic        r_hold;
        bit          ar_seen;
        logic [68:0] ar_snap;
        ar_wait = 0; rd_left = 0; rd_addr = '0; r_hold = 1'b0; ar_seen = 1'b0; ar_snap = '0;
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00;
        axi_rlast = 1'b0; axi_rid = 8'h00; out_ready = 1'b0;
        forever begin
            @(negedge clk);
            tick++;
            if (!rst) begin
                axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
                r_hold = 1'b0; rd_left = 0; ar_wait = 0; ar_seen = 1'b0;
            end else begin
                if (axi_arvalid) begin
                    axi_arready = (ar_wait >= cfg_dly);
                    ar_wait++;
                end else begin
                    axi_arready = 1'b0;
                    ar_wait = 0;
                end
                if (rd_left > 0) begin
                    axi_rvalid = r_hold ? 1'b1 : (cfg_gap ? ($urandom_range(2) != 0) : 1'b1);
                    axi_rdata  = mem_word(rd_addr);
                    axi_rresp  = (cmd_beat == cfg_err_beat) ? 2'b10 : 2'b00;
                    axi_rlast  = (rd_left == 1);
                    axi_rid    = 8'($urandom);
                end else begin
                    axi_rvalid = 1'b0;
                    axi_rlast  = 1'b0;
                    axi_rresp  = 2'b00;
                end
                case (cfg_rmode)
                    0: out_ready = 1'b1;
                    1: out_ready = (tick % 2 == 0);
                    default: out_ready = 1'($urandom_range(1));
                endcase
            end
            #1;
            if (rst) begin
                if (axi_arvalid) begin
                    if (!ar_seen) begin
                        ar_seen = 1'b1;
                        ar_snap = ar_bus;
                    end else if (ar_bus !== ar_snap) begin
                        proto_err++;
                    end
                end
                if (axi_arvalid && axi_arready) begin
                    ar_q.push_back('{axi_araddr, axi_arlen, ar_bus[28:0]});
                    ar_seen = 1'b0;
                    rd_addr = axi_araddr;
                    rd_left = int'(axi_arlen) + 1;
                end
                if (out_valid !== axi_rvalid) proto_err++;
                if (axi_rvalid && ((axi_rready !== out_ready) || (out_data !== axi_rdata))) proto_err++;
                if (axi_rvalid && axi_rready) begin
                    rd_addr = rd_addr + 32'd4;
                    rd_left--;
                    cmd_beat++;
                    r_hold = 1'b0;
                end else begin
                    r_hold = axi_rvalid;
                end
                if (out_valid && out_ready) begin
                    out_q.push_back('{out_data, out_last});
                    last_tick = tick;
                end
                if (done) begin
                    done_cnt++;
                    done_tick = tick;
                    err_at_done = err;
                end
            end
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_cmd(input logic [31:0] a, input int unsigned n, input int unsigned dly,
                           input int unsigned rm, input int eb, input bit gap, input string tag);
        int unsigned t_acc, budget, waited, nchk;
        logic [31:0] base;
        bit exp_err;
        cfg_dly = dly; cfg_rmode = rm; cfg_err_beat = eb; cfg_gap = gap;
        ar_q.delete(); out_q.delete();
        done_cnt = 0; proto_err = 0; cmd_beat = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = 16'(n);
        #2;
        check({tag, ":cmd_ready"}, 64'(cmd_ready), 64'd1);
        t_acc = tick;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 16'($urandom);
        #2;
        check({tag, ":err_clr"}, 64'(err), 64'd0);
        check({tag, ":busy"}, 64'(busy), 64'd1);
        waited = 0;
        budget = n * 12 + 60;
        while (done_cnt == 0 && waited < budget) begin
            @(negedge clk);
            #2;
            waited++;
        end
        if (done_cnt == 0) begin
            check({tag, ":done_timeout"}, 64'(done_cnt), 64'd1);
            pulse_reset();
            return;
        end
        repeat (3) @(negedge clk);
        #2;
        check({tag, ":done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, ":idle_busy"}, 64'(busy), 64'd0);
        check({tag, ":done_tick"}, 64'(done_tick), 64'(((n == 0) ? t_acc : last_tick) + 1));
        exp_err = (eb >= 0) && (eb < int'(n));
        check({tag, ":err_at_done"}, 64'(err_at_done), 64'(exp_err));
        check({tag, ":err_sticky"}, 64'(err), 64'(exp_err));
        check({tag, ":proto"}, 64'(proto_err), 64'd0);
        model_bursts(a, n);
        check({tag, ":ar_count"}, 64'(ar_q.size()), 64'(exp_ar.size()));
        nchk = (ar_q.size() < exp_ar.size()) ? ar_q.size() : exp_ar.size();
        for (int i = 0; i < int'(nchk); i++) begin
            check($sformatf("%s:araddr[%0d]", tag, i), 64'(ar_q[i].addr), 64'(exp_ar[i].addr));
            check($sformatf("%s:arlen[%0d]", tag, i), 64'(ar_q[i].len), 64'(exp_ar[i].len));
            check($sformatf("%s:arfix[%0d]", tag, i), 64'(ar_q[i].fixed), 64'(exp_ar[i].fixed));
        end
        check({tag, ":word_count"}, 64'(out_q.size()), 64'(n));
        base = a & ~32'h3;
        nchk = (out_q.size() < n) ? out_q.size() : n;
        for (int i = 0; i < int'(nchk); i++) begin
            check($sformatf("%s:data[%0d]", tag, i), 64'(out_q[i].data), 64'(mem_word(base + 32'(4 * i))));
            check($sformatf("%s:last[%0d]", tag, i), 64'(out_q[i].last), 64'(i == int'(n) - 1));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t vecs[10];
        int unsigned w;
        vecs[0] = '{32'h0000_1000, 16, 0, 0, -1, 1'b0, 1, 8'd15, 1'b0};
        vecs[1] = '{32'h0000_0FF8,  8, 0, 0, -1, 1'b0, 2, 8'd1,  1'b0};
        vecs[2] = '{32'h0000_0000, 40, 0, 0, -1, 1'b0, 3, 8'd15, 1'b0};
        vecs[3] = '{32'h0000_2000, 20, 3, 1, -1, 1'b0, 2, 8'd15, 1'b0};
        vecs[4] = '{32'h0000_3000,  4, 0, 0,  2, 1'b0, 1, 8'd3,  1'b1};
        vecs[5] = '{32'h0000_4000,  0, 0, 0, -1, 1'b0, 0, 8'd0,  1'b0};
        vecs[6] = '{32'h0000_5003,  3, 1, 2, -1, 1'b1, 1, 8'd2,  1'b0};
        vecs[7] = '{32'h0000_0FFC,  3, 0, 0, -1, 1'b0, 2, 8'd0,  1'b0};
        vecs[8] = '{32'hFFFF_FFF8,  4, 0, 2, -1, 1'b1, 2, 8'd1,  1'b0};
        vecs[9] = '{32'h0000_7FC0, 17, 2, 2, -1, 1'b1, 2, 8'd15, 1'b0};

        rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst:arvalid", 64'(axi_arvalid), 64'd0);
        check("rst:rready", 64'(axi_rready), 64'd0);
        check("rst:out_valid", 64'(out_valid), 64'd0);
        check("rst:busy", 64'(busy), 64'd0);
        check("rst:done", 64'(done), 64'd0);
        check("rst:err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("rel:cmd_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].addr, vecs[i].len, vecs[i].dly, vecs[i].rmode, vecs[i].err_beat,
                    vecs[i].gap, $sformatf("vec%0d", i));
            check($sformatf("vec%0d:bursts", i), 64'(ar_q.size()), 64'(vecs[i].exp_bursts));
            if (vecs[i].exp_bursts != 0 && ar_q.size() != 0)
                check($sformatf("vec%0d:arlen0", i), 64'(ar_q[0].len), 64'(vecs[i].exp_arlen0));
            check($sformatf("vec%0d:err", i), 64'(err), 64'(vecs[i].exp_err));
        end

        // Asynchronous reset in the middle of a data phase
        cfg_dly = 0; cfg_rmode = 0; cfg_gap = 1'b0; cfg_err_beat = -1;
        ar_q.delete(); out_q.delete();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 32'h0000_6000; cmd_len = 16'd32;
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while (out_q.size() < 3 && w < 200) begin
            @(negedge clk);
            #2;
            w++;
        end
        check("mid:reach_data", 64'(out_q.size() >= 3), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("mid:arvalid", 64'(axi_arvalid), 64'd0);
        check("mid:rready", 64'(axi_rready), 64'd0);
        check("mid:out_valid", 64'(out_valid), 64'd0);
        check("mid:busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #2;
        check("mid:cmd_ready", 64'(cmd_ready), 64'd1);
        check("mid:err", 64'(err), 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int unsigned n;
            int eb;
            a = $urandom;
            if ($urandom_range(1) == 1) a[11:8] = 4'hF;
            n = $urandom_range(0, 50);
            eb = ($urandom_range(3) == 0) ? int'($urandom_range(0, n)) : -1;
            run_cmd(a, n, $urandom_range(0, 3), 2, eb, 1'b1, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_read_burst_master.md
Name: axi_read_burst_master

Overview:
- AXI4 read-only master that drives the AR/R half of the team's AXI4 test interface and feeds the systolic-array input buffers.
- Accepts a command (start address, word count) and splits it into INCR bursts, each no longer than MAX_BURST and never crossing a 4 KB boundary.
- Forwards returned R beats as a valid/ready stream with a last flag, and reports completion and error status per command.

Parameters:
- DATA_WIDTH, 32, AXI data width in bits (power of two, >= 32).
- ADDR_WIDTH, 32, AXI address width.
- STRB_WIDTH, DATA_WIDTH/8, bytes per beat.
- ID_WIDTH, 8, AXI ID width.
- ARID, 0, fixed ID driven on axi_arid.
- MAX_BURST, 16, maximum beats per burst (1..256).
- LEN_WIDTH, 16, width of the command word count.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_addr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits ignored (forced 0).
- cmd_len  in  LEN_WIDTH  number of words to read.
- axi_arid  out  ID_WIDTH  = ARID.
- axi_araddr  out  ADDR_WIDTH  burst start address.
- axi_arlen  out  8  beats-1.
- axi_arsize  out  3  = log2(STRB_WIDTH).
- axi_arburst  out  2  = 2'b01 (INCR).
- axi_arlock  out  1  = 0.
- axi_arcache  out  4  = 4'b0011.
- axi_arprot  out  3  = 0.
- axi_arqos  out  4  = 0.
- axi_arregion  out  4  = 0.
- axi_arvalid  out  1  address valid.
- axi_arready  in  1  address ready.
- axi_rid  in  ID_WIDTH  ignored.
- axi_rdata  in  DATA_WIDTH  read data.
- axi_rresp  in  2  read response.
- axi_rlast  in  1  last beat of burst.
- axi_rvalid  in  1  read data valid.
- axi_rready  out  1  read data ready.
- out_data  out  DATA_WIDTH  streamed word.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  final word of the command.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at command end.
- err  out  1  sticky error for the current/last command.

Behaviour:
- Reset (rst=0, async): state IDLE; arvalid=0, rready=0, out_valid=0, done=0, err=0, busy=0, cmd_ready=1 after release.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: cmd_ready=1.
  - On cmd_valid: latch aligned addr and remaining=cmd_len; clear err.
  - cmd_len=0 -> DONE; otherwise -> ADDR.
  - cmd_ready=0 outside IDLE.
- ADDR: beats = min(remaining, MAX_BURST, (4096 - addr[11:0]) >> log2(STRB_WIDTH)), registered on entry.
  - arvalid=1 with araddr=addr and arlen=beats-1; all AR fields held stable until arready.
  - On handshake: addr += beats*STRB_WIDTH, remaining -= beats, beat_cnt=beats -> DATA.
- DATA: combinational pass-through with zero added latency.
  - rready=out_ready, out_valid=rvalid, out_data=rdata.
  - out_last = rvalid && beat_cnt==1 && remaining==0.
  - Each R handshake decrements beat_cnt.
  - rresp != 2'b00 sets err.
  - rlast disagreeing with beat_cnt==1 sets err.
  - Burst end is decided by beat_cnt alone: when beat_cnt reaches 0, go to ADDR if remaining>0, else DONE.
- DONE: done=1 for exactly one cycle -> IDLE; err stays valid until the next command is accepted.
- Only one burst is outstanding at a time; AR for burst n+1 is issued the cycle after the last beat of burst n.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no error is raised.
- cmd_valid while busy is ignored (held off by cmd_ready=0).

Decomposition:
- Package axi_pkg holds:
  - burst encodings (FIXED/INCR/WRAP);
  - resp codes (OKAY/EXOKAY/SLVERR/DECERR);
  - the 4 KB boundary constant;
  - the FSM state typedef.
- Sub-module axi_burst_calc: combinational beats = min(remaining, MAX_BURST, words-to-4KB). Its output is registered in the parent.

Test Plan:
- addr 0x1000, len 16, MAX_BURST 16 -> one AR (araddr 0x1000, arlen 15, arsize 2, arburst 1); 16 words out; out_last on word 16; done one cycle later; err=0.
- addr 0x0FF8, len 8 -> AR 0x0FF8 arlen 1, then AR 0x1000 arlen 5; out_last only on word 8.
- addr 0x0, len 40 -> ARs at 0x00/0x40/0x80 with arlen 15/15/7; 40 words in order.
- arready delayed 3 cycles and out_ready toggling 1010 -> AR fields stable while arvalid=1; rready tracks out_ready; no word lost or duplicated.
- rresp=2'b10 on beat 3 of len 4 -> all 4 words delivered, err=1 at done; next command accept clears err to 0.
- len 0 -> no arvalid, done pulse one cycle after accept. Separately, rst low mid-DATA -> arvalid/rready/out_valid/busy=0 immediately, cmd_ready=1 after release.
